// File: rtl/ball_motion_ctrl.sv
// Pong ball direction/speed controller: serve, bounce, speed-up and miss sequencing.
// Each axis advances with a phase accumulator; a carry out becomes a one-cycle step enable.
module ball_motion_ctrl #(
  parameter int ACC_W       = 4,
  parameter int INIT_SPEED  = 4,
  parameter int MAX_SPEED   = 12,
  parameter int ACCEL_HITS  = 2,
  parameter int SERVE_TICKS = 8,
  parameter int HOLD_TICKS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             serve,
  input  logic             serve_dir,
  input  logic             hit_top,
  input  logic             hit_bottom,
  input  logic             paddle_l,
  input  logic             paddle_r,
  input  logic [1:0]       paddle_zone,
  input  logic             miss_l,
  input  logic             miss_r,
  output logic             x_en,
  output logic             x_up,
  output logic             y_en,
  output logic             y_up,
  output logic [ACC_W-1:0] x_speed,
  output logic [ACC_W-1:0] y_speed,
  output logic             point_l,
  output logic             point_r,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int MAX_TICKS = (SERVE_TICKS > HOLD_TICKS) ? SERVE_TICKS : HOLD_TICKS;
  localparam int TCNT_W    = $clog2(MAX_TICKS + 1);
  localparam int HCNT_W    = $clog2(ACCEL_HITS + 1);

  localparam logic [ACC_W-1:0]  INIT_SPD   = ACC_W'(INIT_SPEED);
  localparam logic [ACC_W-1:0]  MAX_SPD    = ACC_W'(MAX_SPEED);
  localparam logic [ACC_W-1:0]  SLOW_Y     = ACC_W'(1);
  localparam logic [ACC_W-1:0]  FAST_Y     = ACC_W'(3);
  localparam logic [TCNT_W-1:0] SERVE_LAST = TCNT_W'(SERVE_TICKS - 1);
  localparam logic [TCNT_W-1:0] HOLD_LAST  = TCNT_W'(HOLD_TICKS - 1);
  localparam logic [HCNT_W-1:0] HITS_LAST  = HCNT_W'(ACCEL_HITS - 1);

  state_e            state_q, state_d;
  logic              x_en_q, x_en_d, y_en_q, y_en_d;
  logic              x_up_q, x_up_d, y_up_q, y_up_d;
  logic [ACC_W-1:0]  x_speed_q, x_speed_d, y_speed_q, y_speed_d;
  logic [ACC_W-1:0]  x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [HCNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              point_l_q, point_l_d, point_r_q, point_r_d;
  logic              pad_prev_q, pad_prev_d;

  logic [ACC_W:0] x_sum, y_sum;
  logic           pad_any, pad_edge, pad_one;

  assign x_sum    = {1'b0, x_acc_q} + {1'b0, x_speed_q};
  assign y_sum    = {1'b0, y_acc_q} + {1'b0, y_speed_q};
  assign pad_any  = paddle_l | paddle_r;
  assign pad_edge = pad_any & ~pad_prev_q;
  // Contact with both paddles at once is treated as no usable paddle event.
  assign pad_one  = paddle_l ^ paddle_r;

  always_comb begin
    state_d    = state_q;
    x_en_d     = 1'b0;
    y_en_d     = 1'b0;
    x_up_d     = x_up_q;
    y_up_d     = y_up_q;
    x_speed_d  = x_speed_q;
    y_speed_d  = y_speed_q;
    x_acc_d    = x_acc_q;
    y_acc_d    = y_acc_q;
    hit_cnt_d  = hit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    point_l_d  = 1'b0;
    point_r_d  = 1'b0;
    pad_prev_d = pad_any;

    case (state_q)
      IDLE: begin
        if (serve) begin
          state_d    = SERVE;
          x_up_d     = serve_dir;
          y_up_d     = 1'b1;
          x_speed_d  = INIT_SPD;
          y_speed_d  = SLOW_Y;
          x_acc_d    = '0;
          y_acc_d    = '0;
          hit_cnt_d  = '0;
          tick_cnt_d = '0;
        end
      end

      SERVE: begin
        if (tick) begin
          if (tick_cnt_q == SERVE_LAST) begin
            state_d    = PLAY;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      PLAY: begin
        // A miss ends the rally and overrides any paddle or wall event in the same cycle.
        if (miss_l | miss_r) begin
          state_d    = HOLD;
          tick_cnt_d = '0;
          point_r_d  = miss_l & ~miss_r;
          point_l_d  = miss_r & ~miss_l;
        end else begin
          if (tick) begin
            x_en_d  = x_sum[ACC_W];
            y_en_d  = y_sum[ACC_W];
            x_acc_d = x_sum[ACC_W-1:0];
            y_acc_d = y_sum[ACC_W-1:0];
          end
          if (hit_top & ~hit_bottom) begin
            y_up_d = 1'b1;
          end else if (hit_bottom & ~hit_top) begin
            y_up_d = 1'b0;
          end
          if (pad_one) begin
            x_up_d = paddle_l;
          end
          if (pad_one & pad_edge) begin
            if (hit_cnt_q == HITS_LAST) begin
              hit_cnt_d = '0;
              x_speed_d = (x_speed_q >= MAX_SPD) ? MAX_SPD : x_speed_q + 1'b1;
            end else begin
              hit_cnt_d = hit_cnt_q + 1'b1;
            end
            y_up_d    = paddle_zone[1];
            y_speed_d = (paddle_zone == 2'd0 || paddle_zone == 2'd3) ? FAST_Y : SLOW_Y;
          end
        end
      end

      HOLD: begin
        if (tick) begin
          if (tick_cnt_q == HOLD_LAST) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            x_speed_d  = '0;
            y_speed_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_en_q     <= 1'b0;
      y_en_q     <= 1'b0;
      x_up_q     <= 1'b1;
      y_up_q     <= 1'b1;
      x_speed_q  <= '0;
      y_speed_q  <= '0;
      x_acc_q    <= '0;
      y_acc_q    <= '0;
      hit_cnt_q  <= '0;
      tick_cnt_q <= '0;
      point_l_q  <= 1'b0;
      point_r_q  <= 1'b0;
      pad_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_en_q     <= x_en_d;
      y_en_q     <= y_en_d;
      x_up_q     <= x_up_d;
      y_up_q     <= y_up_d;
      x_speed_q  <= x_speed_d;
      y_speed_q  <= y_speed_d;
      x_acc_q    <= x_acc_d;
      y_acc_q    <= y_acc_d;
      hit_cnt_q  <= hit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      point_l_q  <= point_l_d;
      point_r_q  <= point_r_d;
      pad_prev_q <= pad_prev_d;
    end
  end

  assign x_en    = x_en_q;
  assign y_en    = y_en_q;
  assign x_up    = x_up_q;
  assign y_up    = y_up_q;
  assign x_speed = x_speed_q;
  assign y_speed = y_speed_q;
  assign point_l = point_l_q;
  assign point_r = point_r_q;
  assign state   = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed sequences, a zone/bounce vector table and random
// stimulus, all checked every cycle against a rally-level reference model.
module tb_ball_motion_ctrl;

  localparam int ACC_W       = 4;
  localparam int INIT_SPEED  = 4;
  localparam int MAX_SPEED   = 12;
  localparam int ACCEL_HITS  = 2;
  localparam int SERVE_TICKS = 8;
  localparam int HOLD_TICKS  = 16;
  localparam longint SPAN    = longint'(1) << ACC_W;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_HOLD = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic tick = 1'b0, serve = 1'b0, serve_dir = 1'b0;
  logic hit_top = 1'b0, hit_bottom = 1'b0, paddle_l = 1'b0, paddle_r = 1'b0;
  logic [1:0] paddle_zone = 2'd0;
  logic miss_l = 1'b0, miss_r = 1'b0;
  logic x_en, x_up, y_en, y_up, point_l, point_r;
  logic [ACC_W-1:0] x_speed, y_speed;
  logic [1:0] state;

  ball_motion_ctrl #(
    .ACC_W(ACC_W), .INIT_SPEED(INIT_SPEED), .MAX_SPEED(MAX_SPEED),
    .ACCEL_HITS(ACCEL_HITS), .SERVE_TICKS(SERVE_TICKS), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .serve(serve), .serve_dir(serve_dir),
    .hit_top(hit_top), .hit_bottom(hit_bottom), .paddle_l(paddle_l), .paddle_r(paddle_r),
    .paddle_zone(paddle_zone), .miss_l(miss_l), .miss_r(miss_r),
    .x_en(x_en), .x_up(x_up), .y_en(y_en), .y_up(y_up),
    .x_speed(x_speed), .y_speed(y_speed), .point_l(point_l), .point_r(point_r),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tick, serve, serve_dir, hit_top, hit_bottom, paddle_l, paddle_r, miss_l, miss_r;
    logic [1:0] zone;
  } stim_t;

  typedef struct {
    logic pl, pr, top, bot;
    logic [1:0] zone;
    logic exp_xup, exp_yup;
    int exp_yspd;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  // Reference model: the rally phase, distance travelled per axis and tick countdowns.
  int m_state, m_xspd, m_yspd, m_hits, m_left;
  bit m_xen, m_yen, m_xup, m_yup, m_pl, m_pr, m_prev;
  longint m_xph, m_yph;

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic modelReset();
    m_state = S_IDLE; m_xspd = 0; m_yspd = 0; m_hits = 0; m_left = 0;
    m_xen = 0; m_yen = 0; m_xup = 1; m_yup = 1; m_pl = 0; m_pr = 0; m_prev = 0;
    m_xph = 0; m_yph = 0;
  endtask

  task automatic modelStep(input stim_t s);
    bit pad_any, pad_new;
    pad_any = s.paddle_l | s.paddle_r;
    pad_new = pad_any && !m_prev;
    m_xen = 0; m_yen = 0; m_pl = 0; m_pr = 0;
    if (rst) begin
      modelReset();
      return;
    end
    case (m_state)
      S_IDLE: if (s.serve) begin
        m_state = S_SERVE; m_xup = s.serve_dir; m_yup = 1;
        m_xspd = INIT_SPEED; m_yspd = 1; m_xph = 0; m_yph = 0;
        m_hits = 0; m_left = SERVE_TICKS;
      end
      S_SERVE: if (s.tick) begin
        m_left--;
        if (m_left == 0) m_state = S_PLAY;
      end
      S_PLAY: begin
        if (s.miss_l || s.miss_r) begin
          m_state = S_HOLD; m_left = HOLD_TICKS;
          m_pr = s.miss_l && !s.miss_r;
          m_pl = s.miss_r && !s.miss_l;
        end else begin
          if (s.tick) begin
            m_xen = ((m_xph + m_xspd) / SPAN) != (m_xph / SPAN);
            m_yen = ((m_yph + m_yspd) / SPAN) != (m_yph / SPAN);
            m_xph += m_xspd;
            m_yph += m_yspd;
          end
          if (s.hit_top != s.hit_bottom) m_yup = s.hit_top;
          if (s.paddle_l != s.paddle_r) begin
            m_xup = s.paddle_l;
            if (pad_new) begin
              m_hits++;
              if (m_hits == ACCEL_HITS) begin
                m_hits = 0;
                m_xspd = (m_xspd + 1 > MAX_SPEED) ? MAX_SPEED : m_xspd + 1;
              end
              m_yup = (s.zone >= 2);
              m_yspd = (s.zone == 0 || s.zone == 3) ? 3 : 1;
            end
          end
        end
      end
      default: if (s.tick) begin
        m_left--;
        if (m_left == 0) begin
          m_state = S_IDLE; m_xspd = 0; m_yspd = 0;
        end
      end
    endcase
    m_prev = pad_any;
  endtask

  task automatic checkOutput(input string name);
    compared++;
    if (state !== 2'(m_state) || x_en !== m_xen || y_en !== m_yen || x_up !== m_xup ||
        y_up !== m_yup || x_speed !== ACC_W'(m_xspd) || y_speed !== ACC_W'(m_yspd) ||
        point_l !== m_pl || point_r !== m_pr) begin
      mismatched++;
      $display("[TB] FAIL %s: got st=%0d xen=%b yen=%b xup=%b yup=%b xs=%0d ys=%0d pl=%b pr=%b, expected st=%0d xen=%b yen=%b xup=%b yup=%b xs=%0d ys=%0d pl=%b pr=%b",
               name, state, x_en, y_en, x_up, y_up, x_speed, y_speed, point_l, point_r,
               m_state, m_xen, m_yen, m_xup, m_yup, m_xspd, m_yspd, m_pl, m_pr);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input string name);
    tick = s.tick; serve = s.serve; serve_dir = s.serve_dir;
    hit_top = s.hit_top; hit_bottom = s.hit_bottom;
    paddle_l = s.paddle_l; paddle_r = s.paddle_r; paddle_zone = s.zone;
    miss_l = s.miss_l; miss_r = s.miss_r;
    modelStep(s);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  task automatic tickCycle(input string name);
    stim_t s;
    s = zero_stim();
    s.tick = 1'b1;
    applyStimulus(s, name);
  endtask

  task automatic serveToPlay(input logic dir);
    stim_t s;
    s = zero_stim();
    s.serve = 1'b1;
    s.serve_dir = dir;
    applyStimulus(s, "serve");
    for (int i = 0; i < SERVE_TICKS; i++) tickCycle("serve_tick");
  endtask

  task automatic paddleHit(input logic left, input logic [1:0] zone, input string name);
    stim_t s;
    s = zero_stim();
    s.paddle_l = left;
    s.paddle_r = !left;
    s.zone = zone;
    applyStimulus(s, name);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(zero_stim(), "reset");
    rst = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    stim_t s;
    int xcnt, ycnt;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 3};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 3};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1};

    modelReset();
    doReset();
    checkVal("rst_state", state, 0);
    checkVal("rst_xup", x_up, 1);
    checkVal("rst_yup", y_up, 1);
    checkVal("rst_xspeed", x_speed, 0);

    // Serve toward +x, then step cadence at speed 4 (x) and speed 1 (y).
    s = zero_stim(); s.serve = 1'b1; s.serve_dir = 1'b1;
    applyStimulus(s, "serve_cmd");
    checkVal("serve_state", state, 1);
    checkVal("serve_xspeed", x_speed, INIT_SPEED);
    checkVal("serve_yspeed", y_speed, 1);
    checkVal("serve_xup", x_up, 1);
    for (int i = 1; i <= SERVE_TICKS; i++) begin
      tickCycle("serve_tick");
      checkVal("serve_count", state, (i == SERVE_TICKS) ? 2 : 1);
      checkVal("serve_no_step", x_en, 0);
      applyStimulus(zero_stim(), "serve_gap");
    end
    xcnt = 0; ycnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tickCycle("play_tick");
      checkVal("x_step", x_en, (k % 4 == 0) ? 1 : 0);
      checkVal("y_step", y_en, (k == 16) ? 1 : 0);
      xcnt += int'(x_en); ycnt += int'(y_en);
      applyStimulus(zero_stim(), "play_gap");
      checkVal("x_step_width", x_en, 0);
    end
    checkVal("x_step_count", xcnt, 4);
    checkVal("y_step_count", ycnt, 1);

    // Wall contact is forced, so a held or double contact must not toggle direction.
    s = zero_stim(); s.hit_bottom = 1'b1;
    applyStimulus(s, "wall_bottom");
    checkVal("wall_bottom_yup", y_up, 0);
    s = zero_stim(); s.hit_top = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s, "wall_top_held");
      checkVal("wall_top_yup", y_up, 1);
    end
    s.hit_bottom = 1'b1;
    applyStimulus(s, "wall_both");
    checkVal("wall_both_yup", y_up, 1);
    applyStimulus(zero_stim(), "wall_release");

    // Accelerate from 4 to 11, then four right-paddle hits saturate at 12.
    for (int i = 0; i < 14; i++) begin
      paddleHit(i[0], 2'd1, "accel_hit");
      applyStimulus(zero_stim(), "accel_gap");
    end
    checkVal("accel_xspeed_11", x_speed, 11);
    for (int i = 1; i <= 4; i++) begin
      paddleHit(1'b0, 2'd3, "pad_r_hit");
      checkVal("pad_r_xup", x_up, 0);
      checkVal("pad_r_yup", y_up, 1);
      checkVal("pad_r_yspeed", y_speed, 3);
      checkVal("pad_r_xspeed", x_speed, (i == 1) ? 11 : 12);
      applyStimulus(zero_stim(), "pad_r_gap");
    end

    // Miss beats a same-cycle paddle contact.
    s = zero_stim(); s.miss_l = 1'b1; s.paddle_l = 1'b1;
    applyStimulus(s, "miss_l");
    checkVal("miss_point_r", point_r, 1);
    checkVal("miss_point_l", point_l, 0);
    checkVal("miss_state", state, 3);
    checkVal("miss_xup", x_up, 0);
    applyStimulus(zero_stim(), "miss_after");
    checkVal("miss_pulse_width", point_r, 0);
    for (int i = 1; i <= HOLD_TICKS; i++) begin
      tickCycle("hold_tick");
      checkVal("hold_state", state, (i == HOLD_TICKS) ? 0 : 3);
    end
    checkVal("hold_xspeed", x_speed, 0);
    checkVal("hold_yspeed", y_speed, 0);

    // Double miss: no point, still HOLD; serve is ignored there.
    serveToPlay(1'b0);
    s = zero_stim(); s.miss_l = 1'b1; s.miss_r = 1'b1;
    applyStimulus(s, "miss_both");
    checkVal("both_state", state, 3);
    checkVal("both_points", int'(point_l) + int'(point_r), 0);
    s = zero_stim(); s.serve = 1'b1;
    applyStimulus(s, "hold_serve");
    checkVal("hold_serve_state", state, 3);
    for (int i = 0; i < HOLD_TICKS; i++) tickCycle("hold2_tick");
    checkVal("hold2_state", state, 0);

    // Reset in the middle of a rally at x speed 8.
    serveToPlay(1'b1);
    for (int i = 0; i < 8; i++) begin
      paddleHit(i[0], 2'd2, "rst_hit");
      applyStimulus(zero_stim(), "rst_gap");
    end
    checkVal("pre_rst_xspeed", x_speed, 8);
    tickCycle("pre_rst_tick");
    rst = 1'b1;
    #1;
    checkVal("async_rst_state", state, 0);
    checkVal("async_rst_xspeed", x_speed, 0);
    checkVal("async_rst_steps", int'(x_en) + int'(y_en), 0);
    checkVal("async_rst_points", int'(point_l) + int'(point_r), 0);
    @(negedge clk);
    doReset();

    // Zone mapping and wall override table.
    serveToPlay(1'b1);
    foreach (vecs[i]) begin
      s = zero_stim();
      s.paddle_l = vecs[i].pl; s.paddle_r = vecs[i].pr;
      s.hit_top = vecs[i].top; s.hit_bottom = vecs[i].bot; s.zone = vecs[i].zone;
      applyStimulus(s, "vec");
      checkVal("vec_xup", x_up, vecs[i].exp_xup);
      checkVal("vec_yup", y_up, vecs[i].exp_yup);
      checkVal("vec_yspeed", y_speed, vecs[i].exp_yspd);
      applyStimulus(zero_stim(), "vec_gap");
    end

    // Random rallies against the model.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      s.tick       = ($urandom_range(0, 2) == 0);
      s.serve      = ($urandom_range(0, 19) == 0);
      s.serve_dir  = 1'($urandom_range(0, 1));
      s.hit_top    = ($urandom_range(0, 14) == 0);
      s.hit_bottom = ($urandom_range(0, 14) == 0);
      s.paddle_l   = ($urandom_range(0, 9) == 0);
      s.paddle_r   = ($urandom_range(0, 9) == 0);
      s.zone       = 2'($urandom_range(0, 3));
      s.miss_l     = ($urandom_range(0, 199) == 0);
      s.miss_r     = ($urandom_range(0, 199) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      applyStimulus(s, "random");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
